// File: rtl/proc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proc_ctrl_pkg
//  Description : Shared types for the processor run-control block:
//                run-mode and controller-state encodings plus a small helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package proc_ctrl_pkg;

    // Run-mode encoding as presented on the run_mode input.
    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        RSVD = 2'd3
    } run_mode_e;

    // Controller states: wait for synchronised reset, hold everything in
    // reset, release domains one by one, then run-control.
    typedef enum logic [1:0] {
        RST     = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        ACTIVE  = 2'd3
    } ctrl_state_e;

    // Width of the controller state register.
    localparam int c_STATE_W = 2;

    // Larger of two integers; used to size the shared wait counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : proc_ctrl_pkg
`default_nettype wire

// File: rtl/reset_sync.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sync
//  Description : Reset synchroniser. Asserts asynchronously as soon as
//                i_arst_n falls, deasserts synchronously after STAGES rising
//                edges of clk with i_arst_n high.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic i_arst_n,
    output logic o_rst_n
);

    logic [STAGES-1:0] r_sync;

    // Shift ones in once the asynchronous reset has been removed.
    always_ff @(posedge clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], 1'b1};
        end
    end

    assign o_rst_n = r_sync[STAGES-1];

endmodule : reset_sync
`default_nettype wire

// File: rtl/proc_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : proc_run_ctrl
//  Description : Reset sequencing and run control for the processor core.
//                Synchronises the board reset, holds every downstream domain
//                in reset for STRETCH_CYCLES, releases the domains in order
//                GAP_CYCLES apart, then gates the core with a registered
//                clock enable in HALT / RUN / single-STEP mode and counts
//                enabled cycles. A software reset request while running
//                restarts the domain sequence without the synchroniser delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module proc_run_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int NUM_DOMAINS    = 3,
    parameter int STRETCH_CYCLES = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int CNT_W          = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sw_rst_req,
    input  logic [1:0]             run_mode,
    input  logic                   step_req,
    output logic [NUM_DOMAINS-1:0] dom_rst,
    output logic                   ready,
    output logic                   cpu_en,
    output logic [CNT_W-1:0]       cycle_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // One down-counter serves both the stretch and the inter-domain gap, so
    // it is sized for the longer of the two waits.
    localparam int c_WAIT_MAX = max_int(STRETCH_CYCLES, GAP_CYCLES);
    localparam int c_WAIT_W   = $clog2(c_WAIT_MAX + 1);
    localparam int c_IDX_W    = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    // The counter is loaded with N-1 on entry so the event lands N edges later.
    localparam logic [c_WAIT_W-1:0] c_STRETCH_LOAD = c_WAIT_W'(STRETCH_CYCLES - 1);
    localparam logic [c_WAIT_W-1:0] c_GAP_LOAD     = c_WAIT_W'(GAP_CYCLES - 1);
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX     = c_IDX_W'(NUM_DOMAINS - 1);

    localparam logic [c_STATE_W-1:0] c_ST_RST     = RST;
    localparam logic [c_STATE_W-1:0] c_ST_STRETCH = STRETCH;
    localparam logic [c_STATE_W-1:0] c_ST_RELEASE = RELEASE;
    localparam logic [c_STATE_W-1:0] c_ST_ACTIVE  = ACTIVE;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic                   w_sync_rst_n;
    logic [c_STATE_W-1:0]   r_state;
    logic [c_WAIT_W-1:0]    r_wait;
    logic [c_IDX_W-1:0]     r_idx;
    logic [NUM_DOMAINS-1:0] r_dom_rst;
    logic [NUM_DOMAINS-1:0] w_idx_onehot;
    logic                   r_ready;
    logic                   r_cpu_en;
    logic [CNT_W-1:0]       r_cycle_count;
    logic                   r_step_d;
    logic                   w_step_rise;
    logic                   w_sw_rst;
    logic                   w_en_mode;
    run_mode_e              w_mode;

    // ------------------------------------------------------------------------
    // Board reset synchroniser
    // ------------------------------------------------------------------------
    reset_sync #(
        .STAGES (2)
    ) u_reset_sync (
        .clk      (clk),
        .i_arst_n (reset),
        .o_rst_n  (w_sync_rst_n)
    );

    // ------------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------------
    // Software reset only counts once the core is running; during bring-up
    // the sequence is already in progress and the request is dropped.
    assign w_sw_rst    = (r_state == c_ST_ACTIVE) && sw_rst_req;
    assign w_step_rise = step_req && !r_step_d;
    assign w_mode      = run_mode_e'(run_mode);

    // One-hot select of the domain whose reset is released next.
    always_comb begin
        w_idx_onehot = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_idx_onehot[i] = 1'b1;
            end
        end
    end

    // Enable requested by the current run mode; the reserved code halts.
    always_comb begin
        w_en_mode = 1'b0;
        case (w_mode)
            RUN:     w_en_mode = 1'b1;
            STEP:    w_en_mode = w_step_rise;
            default: w_en_mode = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Reset sequencing FSM: stretch, ordered domain release, software reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_ST_RST;
            r_wait    <= '0;
            r_idx     <= '0;
            r_dom_rst <= '1;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_RST: begin
                    if (w_sync_rst_n) begin
                        r_state <= c_ST_STRETCH;
                        r_wait  <= c_STRETCH_LOAD;
                    end
                end

                c_ST_STRETCH: begin
                    if (r_wait == '0) begin
                        r_dom_rst[0] <= 1'b0;
                        if (NUM_DOMAINS == 1) begin
                            // Single domain: no gap wait, straight to running.
                            r_ready <= 1'b1;
                            r_state <= c_ST_ACTIVE;
                        end else begin
                            r_state <= c_ST_RELEASE;
                            r_wait  <= c_GAP_LOAD;
                            r_idx   <= c_IDX_W'(1);
                        end
                    end else begin
                        r_wait <= r_wait - c_WAIT_W'(1);
                    end
                end

                c_ST_RELEASE: begin
                    if (r_wait == '0) begin
                        r_dom_rst <= r_dom_rst & ~w_idx_onehot;
                        if (r_idx == c_LAST_IDX) begin
                            r_ready <= 1'b1;
                            r_state <= c_ST_ACTIVE;
                        end else begin
                            r_idx  <= r_idx + c_IDX_W'(1);
                            r_wait <= c_GAP_LOAD;
                        end
                    end else begin
                        r_wait <= r_wait - c_WAIT_W'(1);
                    end
                end

                c_ST_ACTIVE: begin
                    if (w_sw_rst) begin
                        // Restart from STRETCH; the board reset is already
                        // synchronous so no synchroniser delay is needed.
                        r_dom_rst <= '1;
                        r_ready   <= 1'b0;
                        r_idx     <= '0;
                        r_wait    <= c_STRETCH_LOAD;
                        r_state   <= c_ST_STRETCH;
                    end
                end

                default: begin
                    r_state <= c_ST_RST;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Step request edge detector; always tracks the input so a level held
    // through a mode change or bring-up never produces a late step.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= step_req;
        end
    end

    // ------------------------------------------------------------------------
    // Registered clock enable and enabled-cycle counter.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_en      <= 1'b0;
            r_cycle_count <= '0;
        end else if (w_sw_rst) begin
            // Software reset outranks any run or step request on this edge.
            r_cpu_en      <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            // Count the cycle that is ending if the core was enabled in it;
            // the counter wraps silently.
            if (r_cpu_en) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
            r_cpu_en <= (r_state == c_ST_ACTIVE) && w_en_mode;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all straight from flops)
    // ------------------------------------------------------------------------
    assign dom_rst     = r_dom_rst;
    assign ready       = r_ready;
    assign cpu_en      = r_cpu_en;
    assign cycle_count = r_cycle_count;

endmodule : proc_run_ctrl
`default_nettype wire

// File: tb/tb_proc_run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_proc_run_ctrl
//  Description : Testbench for proc_run_ctrl. Three instances share stimulus:
//                A = defaults, B = 4-bit counter, C = one domain with a
//                one-cycle stretch. A timeline model (edges since sequencing
//                started) predicts every output of every instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_run_ctrl;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic [1:0] run_mode   = 2'd0;
    logic       step_req   = 1'b0;

    logic [2:0]  dom_a;
    logic        ready_a, en_a;
    logic [31:0] cnt_a;
    logic [2:0]  dom_b;
    logic        ready_b, en_b;
    logic [3:0]  cnt_b;
    logic [0:0]  dom_c;
    logic        ready_c, en_c;
    logic [31:0] cnt_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    proc_run_ctrl dut_a (
        .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req), .run_mode(run_mode),
        .step_req(step_req), .dom_rst(dom_a), .ready(ready_a), .cpu_en(en_a),
        .cycle_count(cnt_a)
    );

    proc_run_ctrl #(.CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req), .run_mode(run_mode),
        .step_req(step_req), .dom_rst(dom_b), .ready(ready_b), .cpu_en(en_b),
        .cycle_count(cnt_b)
    );

    proc_run_ctrl #(.NUM_DOMAINS(1), .STRETCH_CYCLES(1)) dut_c (
        .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req), .run_mode(run_mode),
        .step_req(step_req), .dom_rst(dom_c), .ready(ready_c), .cpu_en(en_c),
        .cycle_count(cnt_c)
    );

    // Uniform views of the three instances.
    logic [7:0]  o_dom   [3];
    logic        o_ready [3];
    logic        o_en    [3];
    logic [63:0] o_cnt   [3];

    always_comb begin
        o_dom[0] = {5'd0, dom_a};  o_ready[0] = ready_a; o_en[0] = en_a; o_cnt[0] = {32'd0, cnt_a};
        o_dom[1] = {5'd0, dom_b};  o_ready[1] = ready_b; o_en[1] = en_b; o_cnt[1] = {60'd0, cnt_b};
        o_dom[2] = {7'd0, dom_c};  o_ready[2] = ready_c; o_en[2] = en_c; o_cnt[2] = {32'd0, cnt_c};
    end

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic int p_n(input int d); return (d == 2) ? 1 : 3; endfunction
    function automatic int p_s(input int d); return (d == 2) ? 1 : 4; endfunction
    function automatic int p_g(input int d); return (d < 0) ? 0 : 2;  endfunction
    function automatic int p_w(input int d); return (d == 1) ? 4 : 32; endfunction

    function automatic longint unsigned cnt_mask(input int d);
        return (64'd1 << p_w(d)) - 64'd1;
    endfunction

    // k = edges since the STRETCH entry edge X (k=0 at X), -1 before X.
    function automatic bit ready_of(input int k, input int d);
        return (k >= 0) && (k >= p_s(d) + p_g(d) * (p_n(d) - 1));
    endfunction

    function automatic logic [7:0] dom_of(input int k, input int d);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < p_n(d)) r[i] = !((k >= 0) && (k >= p_s(d) + p_g(d) * i));
        end
        return r;
    endfunction

    int              m_k   [3];
    int              m_pre [3];
    bit              m_en  [3];
    longint unsigned m_cnt [3];
    bit              m_step_prev;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                m_k[d]   <= -1;
                m_pre[d] <= 0;
                m_en[d]  <= 1'b0;
                m_cnt[d] <= 64'd0;
            end
            m_step_prev <= 1'b0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (m_k[d] < 0) begin
                    // Two edges through the synchroniser, X on the third.
                    if (m_pre[d] == 2) m_k[d] <= 0;
                    else               m_pre[d] <= m_pre[d] + 1;
                end else if (ready_of(m_k[d], d) && sw_rst_req) begin
                    m_k[d]   <= 0;
                    m_en[d]  <= 1'b0;
                    m_cnt[d] <= 64'd0;
                end else begin
                    if (m_k[d] < 100000) m_k[d] <= m_k[d] + 1;
                    m_cnt[d] <= (m_cnt[d] + 64'(m_en[d])) & cnt_mask(d);
                    m_en[d]  <= ready_of(m_k[d], d) &&
                                ((run_mode == 2'd1) ||
                                 ((run_mode == 2'd2) && step_req && !m_step_prev));
                end
            end
            m_step_prev <= step_req;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({dom_a, ready_a, en_a, cnt_a} !== {3'b111, 1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL reset_async_a got dom=%b rdy=%b en=%b cnt=%0d required 111/0/0/0",
                     dom_a, ready_a, en_a, cnt_a);
        end
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++;
            if ({dom_b, ready_b, en_b, cnt_b, dom_c, ready_c, en_c, cnt_c} !==
                {3'b111, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 32'd0}) begin
                failures++;
                $display("FAIL reset_hold_bc got b=%b/%b/%b/%0d c=%b/%b/%b/%0d required b=111/0/0/0 c=1/0/0/0",
                         dom_b, ready_b, en_b, cnt_b, dom_c, ready_c, en_c, cnt_c);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_bringup();
        logic [73:0] g_vec, e_vec;
        logic [2:0]  exp_dom;
        run_mode = 2'd1;
        for (int e = 0; e < 18; e++) begin
            tick();   // now just after edge E<e>
            for (int d = 0; d < 3; d++) begin
                g_vec = {o_dom[d], o_ready[d], o_en[d], o_cnt[d]};
                e_vec = {dom_of(m_k[d], d), ready_of(m_k[d], d), m_en[d], m_cnt[d]};
                checks++;
                if (g_vec !== e_vec) begin
                    failures++;
                    $display("FAIL bringup_model dut%0d E%0d got=%h required=%h", d, e, g_vec, e_vec);
                end
            end
            exp_dom = (e < 6) ? 3'b111 : (e < 8) ? 3'b110 : (e < 10) ? 3'b100 : 3'b000;
            checks++;
            if (dom_a !== exp_dom || ready_a !== (e >= 10) || en_a !== (e >= 11)) begin
                failures++;
                $display("FAIL bringup_a E%0d got dom=%b rdy=%b en=%b required dom=%b rdy=%b en=%b",
                         e, dom_a, ready_a, en_a, exp_dom, e >= 10, e >= 11);
            end
            checks++;
            if (dom_c !== ((e < 3) ? 1'b1 : 1'b0) || ready_c !== (e >= 3)) begin
                failures++;
                $display("FAIL bringup_c E%0d got dom=%b rdy=%b required dom=%b rdy=%b",
                         e, dom_c, ready_c, e < 3, e >= 3);
            end
            if (e == 16) begin
                checks++;
                if (cnt_a !== 32'd5) begin
                    failures++;
                    $display("FAIL bringup_count E16 got=%0d required=5", cnt_a);
                end
            end
        end
    endtask

    task automatic test_step();
        logic [73:0]     g_vec, e_vec;
        logic [7:0]      pat;
        logic [7:0]      en_pat;
        longint unsigned base;
        pat    = 8'b0000_1001;   // step pulses at j=0 and j=3
        en_pat = 8'b0000_1001;
        run_mode = 2'd2;
        step_req = 1'b0;
        tick();
        tick();
        base = m_cnt[0];
        for (int j = 0; j < 13; j++) begin
            // j 0..7: two short pulses; j 8..12: held high; then release
            step_req = (j < 8) ? pat[j] : 1'b1;
            tick();
            for (int d = 0; d < 3; d++) begin
                g_vec = {o_dom[d], o_ready[d], o_en[d], o_cnt[d]};
                e_vec = {dom_of(m_k[d], d), ready_of(m_k[d], d), m_en[d], m_cnt[d]};
                checks++;
                if (g_vec !== e_vec) begin
                    failures++;
                    $display("FAIL step_model dut%0d j=%0d got=%h required=%h", d, j, g_vec, e_vec);
                end
            end
            checks++;
            if (en_a !== ((j < 8) ? en_pat[j] : (j == 8))) begin
                failures++;
                $display("FAIL step_pulse j=%0d got en=%b required en=%b", j, en_a,
                         (j < 8) ? en_pat[j] : (j == 8));
            end
            if (j == 7) begin
                checks++;
                if (64'(cnt_a) !== base + 64'd2) begin
                    failures++;
                    $display("FAIL step_count2 got=%0d required=%0d", cnt_a, base + 2);
                end
            end
        end
        step_req = 1'b0;
        tick();
        checks++;
        if (64'(cnt_a) !== base + 64'd3) begin
            failures++;
            $display("FAIL step_held_count got=%0d required=%0d", cnt_a, base + 3);
        end
    endtask

    task automatic test_sw_reset();
        logic [73:0] g_vec, e_vec;
        run_mode = 2'd1;
        for (int j = 0; j < 12; j++) tick();
        sw_rst_req = 1'b1;
        tick();   // edge S
        checks++;
        if ({dom_a, ready_a, en_a, cnt_a} !== {3'b111, 1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL swrst_clear got dom=%b rdy=%b en=%b cnt=%0d required 111/0/0/0",
                     dom_a, ready_a, en_a, cnt_a);
        end
        tick();   // edge S+1: request still high, ignored while sequencing
        sw_rst_req = 1'b0;
        checks++;
        if (dom_c !== 1'b0 || ready_c !== 1'b1 || dom_a !== 3'b111) begin
            failures++;
            $display("FAIL swrst_ignored got c_dom=%b c_rdy=%b a_dom=%b required 0/1/111",
                     dom_c, ready_c, dom_a);
        end
        for (int s = 2; s <= 9; s++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                g_vec = {o_dom[d], o_ready[d], o_en[d], o_cnt[d]};
                e_vec = {dom_of(m_k[d], d), ready_of(m_k[d], d), m_en[d], m_cnt[d]};
                checks++;
                if (g_vec !== e_vec) begin
                    failures++;
                    $display("FAIL swrst_model dut%0d S+%0d got=%h required=%h", d, s, g_vec, e_vec);
                end
            end
            checks++;
            if (dom_a[0] !== (s < 4) || ready_a !== (s >= 8)) begin
                failures++;
                $display("FAIL swrst_seq S+%0d got dom0=%b rdy=%b required dom0=%b rdy=%b",
                         s, dom_a[0], ready_a, s < 4, s >= 8);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [73:0] g_vec, e_vec;
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        for (int s = 1; s <= 4; s++) tick();
        checks++;
        if (dom_a !== 3'b110) begin
            failures++;
            $display("FAIL arst_setup got dom=%b required=110", dom_a);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({dom_a, ready_a, en_a, cnt_a, dom_c, ready_c, en_c, cnt_c} !==
            {3'b111, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL arst_immediate got a=%b/%b/%b/%0d c=%b/%b/%b/%0d required a=111/0/0/0 c=1/0/0/0",
                     dom_a, ready_a, en_a, cnt_a, dom_c, ready_c, en_c, cnt_c);
        end
        tick();
        tick();
        reset = 1'b1;
        for (int e = 0; e < 12; e++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                g_vec = {o_dom[d], o_ready[d], o_en[d], o_cnt[d]};
                e_vec = {dom_of(m_k[d], d), ready_of(m_k[d], d), m_en[d], m_cnt[d]};
                checks++;
                if (g_vec !== e_vec) begin
                    failures++;
                    $display("FAIL arst_model dut%0d E%0d got=%h required=%h", d, e, g_vec, e_vec);
                end
            end
            if (e == 5 || e == 6 || e == 10) begin
                checks++;
                if (dom_a !== ((e == 5) ? 3'b111 : (e == 6) ? 3'b110 : 3'b000) || ready_a !== (e == 10)) begin
                    failures++;
                    $display("FAIL arst_reseq E%0d got dom=%b rdy=%b", e, dom_a, ready_a);
                end
            end
        end
    endtask

    task automatic test_wrap_halt();
        logic [73:0] g_vec, e_vec;
        run_mode = 2'd1;
        sw_rst_req = 1'b1;
        tick();   // edge S
        sw_rst_req = 1'b0;
        for (int s = 1; s <= 26; s++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                g_vec = {o_dom[d], o_ready[d], o_en[d], o_cnt[d]};
                e_vec = {dom_of(m_k[d], d), ready_of(m_k[d], d), m_en[d], m_cnt[d]};
                checks++;
                if (g_vec !== e_vec) begin
                    failures++;
                    $display("FAIL wrap_model dut%0d S+%0d got=%h required=%h", d, s, g_vec, e_vec);
                end
            end
        end
        // cpu_en high from S+9; 17 enabled cycles end at S+26
        checks++;
        if (cnt_b !== 4'd1) begin
            failures++;
            $display("FAIL wrap_count got=%0d required=1", cnt_b);
        end
        run_mode = 2'd0;
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++;
            if (en_b !== 1'b0 || cnt_b !== 4'd2) begin
                failures++;
                $display("FAIL halt_freeze T+%0d got en=%b cnt=%0d required en=0 cnt=2", t, en_b, cnt_b);
            end
        end
    endtask

    task automatic test_reserved_mode();
        run_mode = 2'd1;
        tick();
        tick();
        run_mode = 2'd3;
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++;
            if ({en_a, en_b, en_c} !== 3'b000 || en_a !== m_en[0] || cnt_c !== 32'(m_cnt[2])) begin
                failures++;
                $display("FAIL rsvd_mode T+%0d got en=%b%b%b cnt_c=%0d required en=000 cnt_c=%0d",
                         t, en_a, en_b, en_c, cnt_c, m_cnt[2]);
            end
        end
    endtask

    task automatic test_random();
        logic [73:0] g_vec, e_vec;
        int rst_hold;
        rst_hold = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) run_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) step_req = ~step_req;
            sw_rst_req = ($urandom_range(0, 39) == 0);
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) reset = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                #3 reset = 1'b0;
                rst_hold = $urandom_range(1, 3);
            end
            tick();
            for (int d = 0; d < 3; d++) begin
                g_vec = {o_dom[d], o_ready[d], o_en[d], o_cnt[d]};
                e_vec = {dom_of(m_k[d], d), ready_of(m_k[d], d), m_en[d], m_cnt[d]};
                checks++;
                if (g_vec !== e_vec) begin
                    failures++;
                    $display("FAIL random_model dut%0d n=%0d got=%h required=%h", d, n, g_vec, e_vec);
                end
            end
        end
        reset      = 1'b1;
        sw_rst_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_step();
        test_sw_reset();
        test_async_reset();
        test_wrap_halt();
        test_reserved_mode();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached t=%0t required completion", $time);
        $fatal(1, "simulation time limit");
    end

endmodule : tb_proc_run_ctrl
`default_nettype wire
